// File: rtl/crc_frame_packer_pkg.sv
// Shared constants and types for the CRC frame packer and its neighbours.
// The CRC engine uses the same payload byte count, so it lives here.
package crc_frame_packer_pkg;

  localparam int         PAYLOAD_BYTES_DEF = 8;
  localparam logic [7:0] SOF_BYTE_DEF      = 8'h7E;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_CRC_HI   = 3'd2,
    ST_SEND_SOF = 3'd3,
    ST_SEND_PAY = 3'd4,
    ST_SEND_LO  = 3'd5,
    ST_SEND_HI  = 3'd6
  } state_e;

  // True for every state that presents a byte to the transmitter.
  function automatic logic is_send_state(input state_e s);
    return (s == ST_SEND_SOF) || (s == ST_SEND_PAY) ||
           (s == ST_SEND_LO)  || (s == ST_SEND_HI);
  endfunction

endpackage

// File: rtl/crc_frame_packer_if.sv
// Byte-level bus between the CRC engine / UART transmitter side and the packer.
// The master side feeds payload and CRC bytes and provides tx_ready; the slave
// side is the packer itself.
interface crc_frame_packer_if;
  import crc_frame_packer_pkg::*;

  byte_t pay_data;
  logic  pay_we;
  byte_t crc_byte;
  logic  crc_done;
  byte_t tx_data;
  logic  tx_valid;
  logic  tx_ready;
  logic  busy;
  logic  frame_sent;
  logic  frame_err;
  logic  overflow;

  modport master (
    output pay_data, pay_we, crc_byte, crc_done, tx_ready,
    input  tx_data, tx_valid, busy, frame_sent, frame_err, overflow
  );

  modport slave (
    input  pay_data, pay_we, crc_byte, crc_done, tx_ready,
    output tx_data, tx_valid, busy, frame_sent, frame_err, overflow
  );

endinterface

// File: rtl/crc_frame_packer_frame_byte_buffer.sv
// Payload register file: one synchronous write port, one combinational read
// port. Contents are never reset; a frame always rewrites every slot it reads.
module frame_byte_buffer
  import crc_frame_packer_pkg::*;
#(
  parameter int DEPTH = PAYLOAD_BYTES_DEF,
  parameter int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IDXW-1:0] widx_i,
  input  byte_t           wdata_i,
  input  logic [IDXW-1:0] ridx_i,
  output byte_t           rdata_o
);

  byte_t mem_q [DEPTH];

  // Store the incoming payload byte at the requested slot.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/crc_frame_packer.sv
// Collects the payload bytes seen by the CRC engine plus the two CRC bytes it
// emits, then streams SOF, payload, CRC low, CRC high to the UART transmitter
// over a valid/ready byte handshake. tx_data/tx_valid are registered and are
// computed from the next state so consecutive bytes go out without bubbles.
module crc_frame_packer
  import crc_frame_packer_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = PAYLOAD_BYTES_DEF,
  parameter logic [7:0] SOF_BYTE      = SOF_BYTE_DEF
) (
  input logic               clk_i,
  input logic               reset_i,
  crc_frame_packer_if.slave bus
);

  localparam int              CNTW       = $clog2(PAYLOAD_BYTES + 1);
  localparam int              IDXW       = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [CNTW-1:0] COUNT_FULL = CNTW'(PAYLOAD_BYTES);
  localparam logic [IDXW-1:0] INDEX_LAST = IDXW'(PAYLOAD_BYTES - 1);

  state_e          state_q, state_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [IDXW-1:0] index_q, index_d;
  byte_t           crc_lo_q, crc_lo_d;
  byte_t           crc_hi_q, crc_hi_d;
  logic            crc_done_q;
  byte_t           tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            frame_sent_q, frame_sent_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;

  logic            crc_rise;
  logic            accept;
  logic            buf_we;
  logic [IDXW-1:0] buf_widx;
  byte_t           buf_rdata;

  assign crc_rise = bus.crc_done && !crc_done_q;
  assign accept   = tx_valid_q && bus.tx_ready;

  frame_byte_buffer #(
    .DEPTH (PAYLOAD_BYTES),
    .IDXW  (IDXW)
  ) u_buffer (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .widx_i  (buf_widx),
    .wdata_i (bus.pay_data),
    .ridx_i  (index_d),
    .rdata_o (buf_rdata)
  );

  // Next-state logic: payload capture, CRC latching, send sequencing and pulses.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    index_d      = index_q;
    crc_lo_d     = crc_lo_q;
    crc_hi_d     = crc_hi_q;
    buf_we       = 1'b0;
    buf_widx     = count_q[IDXW-1:0];
    overflow_d   = 1'b0;
    frame_err_d  = 1'b0;
    frame_sent_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.pay_we) begin
          buf_we   = 1'b1;
          buf_widx = '0;
          count_d  = CNTW'(1);
          state_d  = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (crc_rise) begin
          overflow_d = bus.pay_we;
          if (count_q == COUNT_FULL) begin
            crc_lo_d = bus.crc_byte;
            state_d  = ST_CRC_HI;
          end else begin
            frame_err_d = 1'b1;
            count_d     = '0;
            state_d     = ST_IDLE;
          end
        end else if (bus.pay_we) begin
          if (count_q == COUNT_FULL) begin
            overflow_d = 1'b1;
          end else begin
            buf_we  = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
      end

      ST_CRC_HI: begin
        overflow_d = bus.pay_we;
        crc_hi_d   = bus.crc_byte;
        index_d    = '0;
        state_d    = ST_SEND_SOF;
      end

      ST_SEND_SOF: begin
        overflow_d = bus.pay_we;
        if (accept) begin
          state_d = ST_SEND_PAY;
        end
      end

      ST_SEND_PAY: begin
        overflow_d = bus.pay_we;
        if (accept) begin
          if (index_q == INDEX_LAST) begin
            state_d = ST_SEND_LO;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end

      ST_SEND_LO: begin
        overflow_d = bus.pay_we;
        if (accept) begin
          state_d = ST_SEND_HI;
        end
      end

      ST_SEND_HI: begin
        overflow_d = bus.pay_we;
        if (accept) begin
          frame_sent_d = 1'b1;
          count_d      = '0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stage the byte for the state being entered so tx_data is ready on arrival.
  always_comb begin
    tx_valid_d = is_send_state(state_d);
    tx_data_d  = tx_data_q;
    case (state_d)
      ST_SEND_SOF: tx_data_d = SOF_BYTE;
      ST_SEND_PAY: tx_data_d = buf_rdata;
      ST_SEND_LO:  tx_data_d = crc_lo_q;
      ST_SEND_HI:  tx_data_d = crc_hi_q;
      default:     tx_data_d = tx_data_q;
    endcase
  end

  // State and output registers; crc_done_q resets high so a level already high out of reset is not a rise.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      index_q      <= '0;
      crc_lo_q     <= '0;
      crc_hi_q     <= '0;
      crc_done_q   <= 1'b1;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      frame_sent_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      index_q      <= index_d;
      crc_lo_q     <= crc_lo_d;
      crc_hi_q     <= crc_hi_d;
      crc_done_q   <= bus.crc_done;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      frame_sent_q <= frame_sent_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_sent = frame_sent_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_crc_frame_packer.sv
// Self-checking bench for crc_frame_packer: hand-written timing sequences,
// a table of frame vectors and randomized frames checked against a
// frame-level reference model.
module tb_crc_frame_packer;
  import crc_frame_packer_pkg::*;

  localparam int         P   = PAYLOAD_BYTES_DEF;
  localparam logic [7:0] SOF = SOF_BYTE_DEF;

  typedef struct {
    int         n;
    logic [7:0] base;
    logic [7:0] lo;
    logic [7:0] hi;
    int         readyMode;
    int         expErr;
    int         expOvf;
    int         expLen;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  crc_frame_packer_if bus ();

  crc_frame_packer #(
    .PAYLOAD_BYTES (P),
    .SOF_BYTE      (SOF)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int errors    = 0;
  int checks    = 0;
  int cycleNo   = 0;
  int readyMode = 0;
  int sentCnt   = 0;
  int errCnt    = 0;
  int ovfCnt    = 0;
  int validSeen = 0;
  bit prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;

  logic [7:0] stimPayload [$];
  logic [7:0] expBytes [$];
  logic [7:0] gotBytes [$];

  vec_t vecs [8];

  // Compare one observed value with the value the bench expects.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one clock, then drive tx_ready for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cycleNo++;
    case (readyMode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = ((cycleNo % 4) == 0) || ((cycleNo % 4) == 3);
      default: bus.tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Monitor: records accepted bytes, counts pulses and checks stall holding.
  always @(negedge clk) begin
    if (reset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stallValidHeld", bus.tx_valid, 1);
        checkOutput("stallDataHeld", bus.tx_data, prevData);
      end
      if (bus.tx_valid) validSeen++;
      if (bus.tx_valid && bus.tx_ready) gotBytes.push_back(bus.tx_data);
      if (bus.frame_sent) sentCnt++;
      if (bus.frame_err) errCnt++;
      if (bus.overflow) ovfCnt++;
      prevStall = bus.tx_valid && !bus.tx_ready;
      prevData  = bus.tx_data;
    end
  end

  task automatic clearMonitor();
    gotBytes.delete();
    sentCnt   = 0;
    errCnt    = 0;
    ovfCnt    = 0;
    validSeen = 0;
  endtask

  // Reference model: a full frame is SOF, the first P payload bytes, CRC low, CRC high.
  task automatic buildExpected(input logic [7:0] lo, input logic [7:0] hi);
    expBytes.delete();
    if (stimPayload.size() >= P) begin
      expBytes.push_back(SOF);
      for (int i = 0; i < P; i++) expBytes.push_back(stimPayload[i]);
      expBytes.push_back(lo);
      expBytes.push_back(hi);
    end
  endtask

  task automatic sendPayload(input int n, input bit dropDone, input bit gaps);
    if (dropDone) bus.crc_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.pay_we   = 1'b1;
      bus.pay_data = stimPayload[i];
      step();
      bus.pay_we = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) step();
    end
    bus.pay_we = 1'b0;
  endtask

  task automatic raiseCrc(input logic [7:0] lo, input logic [7:0] hi);
    bus.crc_done = 1'b1;
    bus.crc_byte = lo;
    step();
    bus.crc_byte = hi;
    step();
    bus.crc_byte = 8'($urandom);
  endtask

  task automatic waitDone(input string name);
    int budget = 400;
    while ((sentCnt + errCnt) == 0 && budget > 0) begin
      step();
      budget--;
    end
    checkOutput($sformatf("%s.finishedInBudget", name), (budget > 0) ? 1 : 0, 1);
    repeat (2) step();
  endtask

  task automatic checkFrame(input string name, input int expErr, input int expOvf, input int expLen);
    checkOutput($sformatf("%s.frameErr", name), errCnt, expErr);
    checkOutput($sformatf("%s.overflow", name), ovfCnt, expOvf);
    checkOutput($sformatf("%s.frameSent", name), sentCnt, (expLen > 0) ? 1 : 0);
    checkOutput($sformatf("%s.length", name), gotBytes.size(), expLen);
    for (int i = 0; i < gotBytes.size() && i < expBytes.size(); i++)
      checkOutput($sformatf("%s.byte%0d", name, i), gotBytes[i], expBytes[i]);
    checkOutput($sformatf("%s.busyAfter", name), bus.busy, 0);
    checkOutput($sformatf("%s.validAfter", name), bus.tx_valid, 0);
    if (expLen == 0) checkOutput($sformatf("%s.neverValid", name), validSeen, 0);
  endtask

  // One full frame: drive payload and CRC, then compare against the model.
  task automatic applyStimulus(input vec_t v, input bit randomFill, input bit gaps, input string name);
    readyMode = v.readyMode;
    stimPayload.delete();
    for (int i = 0; i < v.n; i++)
      stimPayload.push_back(randomFill ? 8'($urandom) : 8'(v.base + i));
    clearMonitor();
    sendPayload(v.n, 1'b1, gaps);
    raiseCrc(v.lo, v.hi);
    buildExpected(v.lo, v.hi);
    waitDone(name);
    checkFrame(name, v.expErr, v.expOvf, v.expLen);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t rv;

    vecs[0] = '{8,  8'h01, 8'h3C, 8'hA5, 1, 0, 0, 11};
    vecs[1] = '{5,  8'h40, 8'h11, 8'h22, 0, 1, 0, 0};
    vecs[2] = '{8,  8'h01, 8'h3C, 8'hA5, 0, 0, 0, 11};
    vecs[3] = '{9,  8'hF7, 8'h5A, 8'hC3, 0, 0, 1, 11};
    vecs[4] = '{1,  8'h99, 8'h00, 8'hFF, 2, 1, 0, 0};
    vecs[5] = '{11, 8'h20, 8'h81, 8'h18, 2, 0, 3, 11};
    vecs[6] = '{7,  8'h00, 8'hAA, 8'h55, 1, 1, 0, 0};
    vecs[7] = '{8,  8'hF8, 8'hFF, 8'h00, 2, 0, 0, 11};

    reset        = 1'b1;
    bus.pay_we   = 1'b0;
    bus.pay_data = 8'h00;
    bus.crc_byte = 8'h00;
    bus.crc_done = 1'b1;
    bus.tx_ready = 1'b1;
    step();
    checkOutput("reset.txData", bus.tx_data, 8'h00);
    checkOutput("reset.txValid", bus.tx_valid, 0);
    checkOutput("reset.busy", bus.busy, 0);
    checkOutput("reset.frameSent", bus.frame_sent, 0);
    checkOutput("reset.frameErr", bus.frame_err, 0);
    checkOutput("reset.overflow", bus.overflow, 0);
    reset = 1'b0;
    step();

    // crc_done high out of reset: collection must wait for a real rise.
    clearMonitor();
    stimPayload.delete();
    for (int i = 0; i < P; i++) stimPayload.push_back(8'(i + 1));
    sendPayload(P, 1'b0, 1'b0);
    repeat (5) step();
    checkOutput("levelFromReset.busy", bus.busy, 1);
    checkOutput("levelFromReset.noValid", validSeen, 0);
    bus.crc_done = 1'b0;
    step();

    // Nominal frame timing: SOF two cycles after the rise, 11 back-to-back bytes.
    buildExpected(8'h3C, 8'hA5);
    bus.crc_done = 1'b1;
    bus.crc_byte = 8'h3C;
    step();
    checkOutput("nominal.busyInCrcHi", bus.busy, 1);
    checkOutput("nominal.validAtN1", bus.tx_valid, 0);
    bus.crc_byte = 8'hA5;
    step();
    for (int k = 0; k < P + 3; k++) begin
      checkOutput($sformatf("nominal.valid%0d", k), bus.tx_valid, 1);
      checkOutput($sformatf("nominal.data%0d", k), bus.tx_data, expBytes[k]);
      step();
    end
    checkOutput("nominal.validDrops", bus.tx_valid, 0);
    checkOutput("nominal.frameSentPulse", bus.frame_sent, 1);
    checkOutput("nominal.busyLow", bus.busy, 0);
    step();
    checkOutput("nominal.frameSentOneCycle", bus.frame_sent, 0);
    checkFrame("nominal", 0, 0, P + 3);

    // crc_done held high across a second collection: no frame until a new rise.
    clearMonitor();
    stimPayload.delete();
    for (int i = 0; i < P; i++) stimPayload.push_back(8'(8'h51 + i));
    sendPayload(P, 1'b0, 1'b0);
    repeat (10) step();
    checkOutput("levelHeld.busy", bus.busy, 1);
    checkOutput("levelHeld.noValid", validSeen, 0);
    checkOutput("levelHeld.noSent", sentCnt, 0);
    bus.crc_done = 1'b0;
    step();
    raiseCrc(8'h66, 8'h77);
    buildExpected(8'h66, 8'h77);
    waitDone("levelHeld");
    checkFrame("levelHeld", 0, 0, P + 3);

    // A crc_done rise while idle is ignored.
    clearMonitor();
    bus.crc_done = 1'b0;
    step();
    bus.crc_done = 1'b1;
    repeat (3) step();
    checkOutput("idleRise.busy", bus.busy, 0);
    checkOutput("idleRise.noErr", errCnt, 0);
    checkOutput("idleRise.noValid", validSeen, 0);

    // pay_we during payload transmission is dropped and flagged.
    clearMonitor();
    stimPayload.delete();
    for (int i = 0; i < P; i++) stimPayload.push_back(8'(8'hA0 + i));
    sendPayload(P, 1'b1, 1'b0);
    raiseCrc(8'hC1, 8'hC2);
    repeat (2) step();
    bus.pay_we   = 1'b1;
    bus.pay_data = 8'hEE;
    step();
    bus.pay_we = 1'b0;
    checkOutput("sendOverflow.pulse", bus.overflow, 1);
    step();
    checkOutput("sendOverflow.oneCycle", bus.overflow, 0);
    buildExpected(8'hC1, 8'hC2);
    waitDone("sendOverflow");
    checkFrame("sendOverflow", 0, 1, P + 3);

    // Reset while presenting payload index 3: outputs clear without a clock edge.
    clearMonitor();
    stimPayload.delete();
    for (int i = 0; i < P; i++) stimPayload.push_back(8'(8'h11 + i));
    sendPayload(P, 1'b1, 1'b0);
    raiseCrc(8'h22, 8'h33);
    repeat (4) step();
    checkOutput("midReset.atIndex3", bus.tx_data, 8'h14);
    reset = 1'b1;
    #1;
    checkOutput("midReset.txValid", bus.tx_valid, 0);
    checkOutput("midReset.txData", bus.tx_data, 8'h00);
    checkOutput("midReset.busy", bus.busy, 0);
    step();
    reset = 1'b0;
    step();
    applyStimulus(vecs[2], 1'b0, 1'b0, "afterReset");

    for (int t = 0; t < 8; t++)
      applyStimulus(vecs[t], 1'b0, 1'b0, $sformatf("vec%0d", t));

    for (int r = 0; r < 25; r++) begin
      rv.n         = $urandom_range(1, P + 3);
      rv.base      = 8'h00;
      rv.lo        = 8'($urandom);
      rv.hi        = 8'($urandom);
      rv.readyMode = $urandom_range(0, 2);
      rv.expErr    = (rv.n < P) ? 1 : 0;
      rv.expOvf    = (rv.n > P) ? rv.n - P : 0;
      rv.expLen    = (rv.n >= P) ? P + 3 : 0;
      applyStimulus(rv, 1'b1, 1'b1, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
